jts16_subbus_arb: RTL and testbench
===================================

Name: jts16_subbus_arb

Overview:
Multi-master bus arbiter and address decoder for a secondary 68000 bus. The local CPU normally owns the bus. NREQ external masters (main-CPU windows, DMA engines) take the bus through a registered BR/BG/BGACK handshake with round-robin priority. The block muxes the owner's address, strobes and data onto the shared bus and generates registered ROM/RAM/IO chip selects from a parametrised memory map.

Parameters:
NREQ, 2, number of external requesters (1..4)
AW, 19, word-address width (bus_a[AW-1:0])
DW, 16, data width
ROM_LIM, 3, decode field values below this select ROM
RAM_SEL, 3, decode field value that selects RAM
IO_SEL, 4, decode field value that selects IO
CHAIN, 0, 1 = hand the bus straight to the next pending requester; 0 = always return one cen slot to the CPU

Ports:
clk  in  1  system clock
rst  in  1  reset
cen  in  1  CPU clock enable; all arbitration state advances only on cen
cpu_a  in  AW  CPU word address
cpu_dsn  in  2  CPU {UDSn,LDSn}
cpu_rnw  in  1  CPU read/not-write
cpu_dout  in  DW  CPU write data
cpu_asn  in  1  CPU address strobe
cpu_bgn  in  1  CPU bus grant
cpu_brn  out  1  bus request to CPU
cpu_bgackn  out  1  bus grant acknowledge to CPU
req  in  NREQ  per-master bus request, level
req_a  in  NREQ*AW  flattened requester addresses; channel k at [k*AW +: AW]
req_dsn  in  2*NREQ  flattened requester strobes
req_rnw  in  NREQ  requester read/not-write
req_dout  in  NREQ*DW  flattened requester write data
grant  out  NREQ  one-hot bus ownership
req_ok  out  NREQ  access done for channel k
bus_a  out  AW  muxed address
bus_dsn  out  2  muxed strobes
bus_rnw  out  1  muxed direction
bus_dout  out  DW  muxed write data
bus_ok  in  1  selected memory has completed the access
rom_cs  out  1  ROM select, registered
ram_cs  out  1  RAM select, registered
io_cs  out  1  IO select, registered
bus_busy  out  1  cs active and bus_ok low; feeds DTACK generation

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset: cpu_brn=1, cpu_bgackn=1, grant=0, all cs=0, state IDLE, round-robin pointer=0. Asserting rst mid-transfer returns the block to these values immediately.
- Decode field: bus_a[AW-1:AW-3]. ROM when field < ROM_LIM. RAM when field == RAM_SEL. IO when field == IO_SEL. Any other value selects nothing. At most one cs is high at a time.
- Chip-select timing (every clk): cs is set one clk after a valid access appears. Valid access means either:
  - owner = CPU: cpu_asn=0 and (bus_dsn!=2'b11 or bus_rnw=1);
  - owner = channel k: bus_dsn!=2'b11.
  All cs clear one clk after the access goes invalid. RAM additionally requires bus_dsn!=2'b11.
- Mux: when bus owner is CPU (cpu_bgackn=1), bus_* = cpu_*. Otherwise bus_* = channel selected by grant.
- req_ok[k] = grant[k] & (rom_cs|ram_cs|io_cs) & bus_ok. This is combinational from registered terms.
- FSM (transitions only on cen):
  - IDLE: if |req, set cpu_brn=0 and go to WAITBG.
  - WAITBG: if req becomes all-zero, set cpu_brn=1 and go to IDLE. Else if cpu_bgn=0 and cpu_asn=1:
    - pick winner w = first set req bit scanning from the pointer upward, wrapping;
    - set grant=1<<w, cpu_bgackn=0, cpu_brn=1;
    - go to OWN.
  - OWN: stay while req[w]=1. When req[w]=0 and bus_dsn==2'b11 (no access in flight):
    - clear grant[w] and set pointer=(w+1) mod NREQ;
    - if CHAIN=1 and another req is set, grant the next winner in the same cen and stay in OWN, with cpu_bgackn held low;
    - otherwise go to RELEASE.
  - RELEASE: set cpu_bgackn=1 and go to IDLE. The CPU always gets at least one cen cycle here.
- A requester dropping req while its strobe is active keeps ownership until the strobe clears. An access is never cut mid-cycle.
- A req arriving while the CPU holds AS low waits in WAITBG. No grant is issued while cpu_asn=0.

Test Plan:
- Reset, then CPU read with cpu_a field=1 and asn low: rom_cs=1 one clk later; bus_busy=1 until bus_ok; cs=0 one clk after asn rises. With field=3 and dsn=2'b11, ram_cs stays 0.
- req[0]=1 while cpu_asn=0: cpu_brn=0 on next cen, no grant. After asn=1 and bgn=0: grant=2'b01 and cpu_bgackn=0 on the same cen; bus_a=req_a[0].
- Channel 0 write with field=4, bus_ok delayed 5 clk: io_cs=1, req_ok[0] pulses exactly when bus_ok=1. Dropping req[0] mid-strobe holds grant until dsn=2'b11.
- req=2'b11, CHAIN=0, pointer=0: grant 01, then RELEASE (bgackn=1 for one cen), then a new BR cycle, then grant 10, then pointer=0.
- Same case with CHAIN=1: grant goes 01 to 10 with cpu_bgackn held low throughout.
- Assert rst during OWN with an active cs: all outputs go to reset values asynchronously; after release the FSM is IDLE with pointer 0.

Source files
------------

// File: rtl/jts16_subbus_arb.sv
// Secondary 68000 bus arbiter: round-robin BR/BG/BGACK handoff between the local CPU and
// NREQ external masters, owner-selected bus mux and registered ROM/RAM/IO chip selects.

module jts16_subbus_arb #(
   parameter int NREQ    = 2,
   parameter int AW      = 19,
   parameter int DW      = 16,
   parameter int ROM_LIM = 3,
   parameter int RAM_SEL = 3,
   parameter int IO_SEL  = 4,
   parameter int CHAIN   = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cen,
   input  logic [AW-1:0]      cpu_a,
   input  logic [1:0]         cpu_dsn,
   input  logic               cpu_rnw,
   input  logic [DW-1:0]      cpu_dout,
   input  logic               cpu_asn,
   input  logic               cpu_bgn,
   output logic               cpu_brn,
   output logic               cpu_bgackn,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*AW-1:0] req_a,
   input  logic [2*NREQ-1:0]  req_dsn,
   input  logic [NREQ-1:0]    req_rnw,
   input  logic [NREQ*DW-1:0] req_dout,
   output logic [NREQ-1:0]    grant,
   output logic [NREQ-1:0]    req_ok,
   output logic [AW-1:0]      bus_a,
   output logic [1:0]         bus_dsn,
   output logic               bus_rnw,
   output logic [DW-1:0]      bus_dout,
   input  logic               bus_ok,
   output logic               rom_cs,
   output logic               ram_cs,
   output logic               io_cs,
   output logic               bus_busy
);

   localparam logic [3:0] ROM_LIM_V = 4'(ROM_LIM);
   localparam logic [2:0] RAM_F     = 3'(RAM_SEL);
   localparam logic [2:0] IO_F      = 3'(IO_SEL);
   localparam logic [1:0] LAST      = 2'(NREQ-1);

   typedef enum logic [1:0] {IDLE, WAITBG, OWN, RELEASE} state_t;

   state_t          state, state_nx;
   logic [1:0]      ptr, ptr_nx;
   logic [1:0]      own, own_nx, own_inc;
   logic [1:0]      win_new, win_chain;
   logic [NREQ-1:0] grant_nx;
   logic            brn_nx, bgackn_nx;
   logic            acc_valid;
   logic [2:0]      field;
   logic            dec_rom, dec_ram, dec_io;
   logic            any_cs;

   // First set request at or above p, wrapping round to channel 0
   function automatic logic [1:0] pick_winner(input logic [NREQ-1:0] r, input logic [1:0] p);
      logic [2*NREQ-1:0] rot;
      logic [1:0]        w;
      logic              hit;
      int                wi;
      rot = {r, r} >> p;
      w   = p;
      hit = 1'b0;
      wi  = 0;
      for (int i = 0; i < NREQ; i++) begin
         if (!hit && rot[i]) begin
            wi = int'(p) + i;
            if (wi >= NREQ) wi = wi - NREQ;
            w   = 2'(wi);
            hit = 1'b1;
         end
      end
      return w;
   endfunction

   // With no granted channel (the RELEASE slot) the bus idles with strobes off
   always_comb begin
      bus_a    = cpu_a;
      bus_dsn  = cpu_dsn;
      bus_rnw  = cpu_rnw;
      bus_dout = cpu_dout;
      if (!cpu_bgackn) begin
         bus_a    = '0;
         bus_dsn  = 2'b11;
         bus_rnw  = 1'b1;
         bus_dout = '0;
         for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
               bus_a    = req_a[k*AW +: AW];
               bus_dsn  = req_dsn[2*k +: 2];
               bus_rnw  = req_rnw[k];
               bus_dout = req_dout[k*DW +: DW];
            end
         end
      end
   end

   assign field     = bus_a[AW-1:AW-3];
   assign acc_valid = cpu_bgackn ? (!cpu_asn && (bus_dsn != 2'b11 || bus_rnw))
                                 : (bus_dsn != 2'b11);
   assign dec_rom   = {1'b0, field} < ROM_LIM_V;
   assign dec_ram   = !dec_rom && field == RAM_F && bus_dsn != 2'b11;
   assign dec_io    = !dec_rom && field != RAM_F && field == IO_F;

   // Chip selects follow the bus every clk, independent of cen
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_cs <= 1'b0;
         ram_cs <= 1'b0;
         io_cs  <= 1'b0;
      end else begin
         rom_cs <= acc_valid && dec_rom;
         ram_cs <= acc_valid && dec_ram;
         io_cs  <= acc_valid && dec_io;
      end
   end

   assign any_cs   = rom_cs | ram_cs | io_cs;
   assign bus_busy = any_cs & ~bus_ok;
   assign req_ok   = grant & {NREQ{any_cs & bus_ok}};

   assign own_inc   = (own == LAST) ? 2'd0 : own + 2'd1;
   assign win_new   = pick_winner(req, ptr);
   assign win_chain = pick_winner(req, own_inc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= 2'd0;
         own        <= 2'd0;
         grant      <= '0;
         cpu_brn    <= 1'b1;
         cpu_bgackn <= 1'b1;
      end else begin
         state      <= state_nx;
         ptr        <= ptr_nx;
         own        <= own_nx;
         grant      <= grant_nx;
         cpu_brn    <= brn_nx;
         cpu_bgackn <= bgackn_nx;
      end
   end

   // A channel is released only once its strobes are off, so no access is cut short
   always_comb begin
      state_nx  = state;
      ptr_nx    = ptr;
      own_nx    = own;
      grant_nx  = grant;
      brn_nx    = cpu_brn;
      bgackn_nx = cpu_bgackn;
      if (cen) begin
         case (state)
            IDLE: begin
               if (|req) begin
                  brn_nx   = 1'b0;
                  state_nx = WAITBG;
               end
            end
            WAITBG: begin
               if (!(|req)) begin
                  brn_nx   = 1'b1;
                  state_nx = IDLE;
               end else if (!cpu_bgn && cpu_asn) begin
                  own_nx    = win_new;
                  grant_nx  = NREQ'(1) << win_new;
                  bgackn_nx = 1'b0;
                  brn_nx    = 1'b1;
                  state_nx  = OWN;
               end
            end
            OWN: begin
               if (!(|(req & grant)) && bus_dsn == 2'b11) begin
                  ptr_nx   = own_inc;
                  grant_nx = '0;
                  if (CHAIN != 0 && (|req)) begin
                     own_nx   = win_chain;
                     grant_nx = NREQ'(1) << win_chain;
                  end else begin
                     state_nx = RELEASE;
                  end
               end
            end
            RELEASE: begin
               bgackn_nx = 1'b1;
               state_nx  = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jts16_subbus_arb.sv
// Randomised bench for jts16_subbus_arb: a CHAIN=0 and a CHAIN=1 instance share stimulus and
// are each compared every clk against a handshake-level reference model.

module tb_jts16_subbus_arb;

   localparam int NREQ = 2;
   localparam int AW   = 19;
   localparam int DW   = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic               cen;
   logic [AW-1:0]      cpu_a;
   logic [1:0]         cpu_dsn;
   logic               cpu_rnw;
   logic [DW-1:0]      cpu_dout;
   logic               cpu_asn;
   logic               cpu_bgn;
   logic [NREQ-1:0]    req;
   logic [NREQ*AW-1:0] req_a;
   logic [2*NREQ-1:0]  req_dsn;
   logic [NREQ-1:0]    req_rnw;
   logic [NREQ*DW-1:0] req_dout;
   logic               bus_ok;

   logic               cpu_brn_o    [2];
   logic               cpu_bgackn_o [2];
   logic [NREQ-1:0]    grant_o      [2];
   logic [NREQ-1:0]    req_ok_o     [2];
   logic [AW-1:0]      bus_a_o      [2];
   logic [1:0]         bus_dsn_o    [2];
   logic               bus_rnw_o    [2];
   logic [DW-1:0]      bus_dout_o   [2];
   logic               rom_cs_o     [2];
   logic               ram_cs_o     [2];
   logic               io_cs_o      [2];
   logic               bus_busy_o   [2];

   jts16_subbus_arb #(.CHAIN(0)) u_arb0 (
      .clk(clk), .rst(rst), .cen(cen),
      .cpu_a(cpu_a), .cpu_dsn(cpu_dsn), .cpu_rnw(cpu_rnw), .cpu_dout(cpu_dout),
      .cpu_asn(cpu_asn), .cpu_bgn(cpu_bgn),
      .cpu_brn(cpu_brn_o[0]), .cpu_bgackn(cpu_bgackn_o[0]),
      .req(req), .req_a(req_a), .req_dsn(req_dsn), .req_rnw(req_rnw), .req_dout(req_dout),
      .grant(grant_o[0]), .req_ok(req_ok_o[0]),
      .bus_a(bus_a_o[0]), .bus_dsn(bus_dsn_o[0]), .bus_rnw(bus_rnw_o[0]), .bus_dout(bus_dout_o[0]),
      .bus_ok(bus_ok),
      .rom_cs(rom_cs_o[0]), .ram_cs(ram_cs_o[0]), .io_cs(io_cs_o[0]), .bus_busy(bus_busy_o[0])
   );

   jts16_subbus_arb #(.CHAIN(1)) u_arb1 (
      .clk(clk), .rst(rst), .cen(cen),
      .cpu_a(cpu_a), .cpu_dsn(cpu_dsn), .cpu_rnw(cpu_rnw), .cpu_dout(cpu_dout),
      .cpu_asn(cpu_asn), .cpu_bgn(cpu_bgn),
      .cpu_brn(cpu_brn_o[1]), .cpu_bgackn(cpu_bgackn_o[1]),
      .req(req), .req_a(req_a), .req_dsn(req_dsn), .req_rnw(req_rnw), .req_dout(req_dout),
      .grant(grant_o[1]), .req_ok(req_ok_o[1]),
      .bus_a(bus_a_o[1]), .bus_dsn(bus_dsn_o[1]), .bus_rnw(bus_rnw_o[1]), .bus_dout(bus_dout_o[1]),
      .bus_ok(bus_ok),
      .rom_cs(rom_cs_o[1]), .ram_cs(ram_cs_o[1]), .io_cs(io_cs_o[1]), .bus_busy(bus_busy_o[1])
   );

   // Reference model: handshake lines asserted, current owner (-1 = none) and next-turn pointer
   bit m_br    [2];
   bit m_bgack [2];
   int m_owner [2];
   int m_ptr   [2];
   bit m_rom   [2];
   bit m_ram   [2];
   bit m_io    [2];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic reset_model();
      for (int c = 0; c < 2; c++) begin
         m_br[c]    = 1'b0;
         m_bgack[c] = 1'b0;
         m_owner[c] = -1;
         m_ptr[c]   = 0;
         m_rom[c]   = 1'b0;
         m_ram[c]   = 1'b0;
         m_io[c]    = 1'b0;
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] r, input int p);
      for (int i = 0; i < NREQ; i++) begin
         if (r[(p + i) % NREQ]) return (p + i) % NREQ;
      end
      return -1;
   endfunction

   task automatic expected_bus(input int c, output logic [AW-1:0] a, output logic [1:0] dsn,
                               output logic rnw, output logic [DW-1:0] dout,
                               output bit valid, output bit known);
      a = '0; dsn = 2'b11; rnw = 1'b1; dout = '0; valid = 1'b0; known = 1'b0;
      if (!m_bgack[c]) begin
         a = cpu_a; dsn = cpu_dsn; rnw = cpu_rnw; dout = cpu_dout;
         valid = !cpu_asn && (cpu_dsn != 2'b11 || cpu_rnw);
         known = 1'b1;
      end else if (m_owner[c] >= 0) begin
         a     = req_a[m_owner[c]*AW +: AW];
         dsn   = req_dsn[2*m_owner[c] +: 2];
         rnw   = req_rnw[m_owner[c]];
         dout  = req_dout[m_owner[c]*DW +: DW];
         valid = dsn != 2'b11;
         known = 1'b1;
      end
   endtask

   task automatic check_all();
      logic [AW-1:0]   a;
      logic [1:0]      dsn;
      logic            rnw;
      logic [DW-1:0]   dout;
      bit              valid, known, any;
      logic [NREQ-1:0] g;
      for (int c = 0; c < 2; c++) begin
         expected_bus(c, a, dsn, rnw, dout, valid, known);
         g = '0;
         if (m_owner[c] >= 0) g[m_owner[c]] = 1'b1;
         any = m_rom[c] | m_ram[c] | m_io[c];
         checkOutput($sformatf("c%0d_brn", c), 64'(cpu_brn_o[c]), 64'(!m_br[c]));
         checkOutput($sformatf("c%0d_bgackn", c), 64'(cpu_bgackn_o[c]), 64'(!m_bgack[c]));
         checkOutput($sformatf("c%0d_grant", c), 64'(grant_o[c]), 64'(g));
         checkOutput($sformatf("c%0d_cs", c), 64'({rom_cs_o[c], ram_cs_o[c], io_cs_o[c]}),
                     64'({m_rom[c], m_ram[c], m_io[c]}));
         checkOutput($sformatf("c%0d_busy_ok", c), 64'({bus_busy_o[c], req_ok_o[c]}),
                     64'({any & !bus_ok, g & {NREQ{any & bus_ok}}}));
         if (known)
            checkOutput($sformatf("c%0d_bus", c),
                        64'({bus_a_o[c], bus_dsn_o[c], bus_rnw_o[c], bus_dout_o[c]}),
                        64'({a, dsn, rnw, dout}));
      end
   endtask

   // Advance the model across the coming rising edge using the inputs now on the pins
   task automatic model_step();
      logic [AW-1:0] a;
      logic [1:0]    dsn;
      logic          rnw;
      logic [DW-1:0] dout;
      bit            valid, known;
      int            f, nxt;
      bit            n_rom, n_ram, n_io;
      for (int c = 0; c < 2; c++) begin
         expected_bus(c, a, dsn, rnw, dout, valid, known);
         f     = int'(a[AW-1:AW-3]);
         n_rom = valid && f < 3;
         n_ram = valid && f == 3 && dsn != 2'b11;
         n_io  = valid && f == 4;
         if (cen) begin
            if (m_owner[c] >= 0) begin
               if (!req[m_owner[c]] && dsn == 2'b11) begin
                  m_ptr[c]   = (m_owner[c] + 1) % NREQ;
                  m_owner[c] = -1;
                  if (c == 1 && req != 0) m_owner[c] = pick(req, m_ptr[c]);
               end
            end else if (m_bgack[c]) begin
               m_bgack[c] = 1'b0;
            end else if (m_br[c]) begin
               if (req == 0) m_br[c] = 1'b0;
               else if (!cpu_bgn && cpu_asn) begin
                  nxt        = pick(req, m_ptr[c]);
                  m_owner[c] = nxt;
                  m_bgack[c] = 1'b1;
                  m_br[c]    = 1'b0;
               end
            end else if (req != 0) begin
               m_br[c] = 1'b1;
            end
         end
         m_rom[c] = n_rom;
         m_ram[c] = n_ram;
         m_io[c]  = n_io;
      end
      if (rst) reset_model();
   endtask

   task automatic applyStimulus();
      logic [2:0] fld;
      cen      = ($urandom_range(0, 9) < 6);
      fld      = 3'($urandom_range(0, 7));
      cpu_a    = {fld, 16'($urandom)};
      cpu_dsn  = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'($urandom);
      cpu_rnw  = 1'($urandom);
      cpu_dout = 16'($urandom);
      cpu_asn  = 1'($urandom);
      cpu_bgn  = 1'($urandom);
      for (int k = 0; k < NREQ; k++) begin
         if ($urandom_range(0, 4) == 0) req[k] = ~req[k];
         fld = 3'($urandom_range(0, 7));
         req_a[k*AW +: AW]   = {fld, 16'($urandom)};
         req_dsn[2*k +: 2]   = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'($urandom);
         req_rnw[k]          = 1'($urandom);
         req_dout[k*DW +: DW] = 16'($urandom);
      end
      bus_ok = 1'($urandom);
   endtask

   task automatic run_cycle();
      #1;
      check_all();
      model_step();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; cen = 1'b0; cpu_a = '0; cpu_dsn = 2'b11; cpu_rnw = 1'b1; cpu_dout = '0;
      cpu_asn = 1'b1; cpu_bgn = 1'b1; req = '0; req_a = '0; req_dsn = '1; req_rnw = '1;
      req_dout = '0; bus_ok = 1'b0;
      reset_model();
      @(negedge clk);
      for (int i = 0; i < 3; i++) run_cycle();
      rst = 1'b0;

      for (int i = 0; i < 1500; i++) begin
         applyStimulus();
         run_cycle();
      end

      // Steer channel 0 into a ROM access, then hit reset in the middle of it
      cen = 1'b1; cpu_asn = 1'b1; cpu_bgn = 1'b0; req = 2'b01; bus_ok = 1'b0;
      req_a[0 +: AW] = {3'd1, 16'h1234};
      req_dsn = 4'b1100;
      for (int i = 0; i < 12; i++) run_cycle();
      checkOutput("pre_rst_grant", 64'(grant_o[0]), 64'(2'b01));
      checkOutput("pre_rst_rom", 64'(rom_cs_o[0]), 64'(1));
      #1;
      check_all();
      model_step();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      for (int c = 0; c < 2; c++)
         checkOutput($sformatf("c%0d_async_rst", c),
                     64'({cpu_brn_o[c], cpu_bgackn_o[c], grant_o[c], rom_cs_o[c], ram_cs_o[c], io_cs_o[c]}),
                     64'({1'b1, 1'b1, 2'b00, 3'b000}));
      reset_model();
      @(negedge clk);
      for (int i = 0; i < 2; i++) run_cycle();
      rst = 1'b0;
      req = 2'b11;
      req_dsn = 4'b1111;
      for (int i = 0; i < 4; i++) run_cycle();
      checkOutput("post_rst_ptr0_grant", 64'(grant_o[0]), 64'(2'b01));

      for (int i = 0; i < 1500; i++) begin
         applyStimulus();
         run_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
